// File: rtl/vend_ctrl_param_if.sv
// vend_ctrl_param_if: coin, vend and change handshake bundle for vend_ctrl_param.
// The master side is the acceptor/dispenser/hopper environment.
// The slave side is the vending controller.
interface vend_ctrl_param_if #(
  parameter int CREDIT_W = 8
);
  logic                coin_valid;
  logic [1:0]          coin_sel;
  logic                cancel;
  logic                vend_ack;
  logic                change_ack;
  logic [CREDIT_W-1:0] credit;
  logic                vend_req;
  logic                change_valid;
  logic [1:0]          change_coin;
  logic                coin_reject;
  logic                busy;

  modport master (
    output coin_valid, coin_sel, cancel, vend_ack, change_ack,
    input  credit, vend_req, change_valid, change_coin, coin_reject, busy
  );

  modport slave (
    input  coin_valid, coin_sel, cancel, vend_ack, change_ack,
    output credit, vend_req, change_valid, change_coin, coin_reject, busy
  );
endinterface

// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: parametrised coin vending controller.
// It accumulates credit from three coin values and requests a vend at PRICE.
// Change and refunds are paid out greedily, one coin per hopper ack.
// Optional feature macro: VEND_SALES_CNT_EN adds a saturating 16-bit sales_count output.
module vend_ctrl_param #(
  parameter int PRICE    = 30,
  parameter int CREDIT_W = 8,
  parameter int COIN_A   = 5,
  parameter int COIN_B   = 10,
  parameter int COIN_C   = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  vend_ctrl_param_if.slave      bus
`ifdef VEND_SALES_CNT_EN
  ,
  output logic [15:0]           sales_count
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_VEND   = 2'd2;
  localparam logic [1:0] S_CHANGE = 2'd3;

  localparam int SW = CREDIT_W + 1;
  localparam logic [CREDIT_W:0]   VAL_A   = SW'(COIN_A);
  localparam logic [CREDIT_W:0]   VAL_B   = SW'(COIN_B);
  localparam logic [CREDIT_W:0]   VAL_C   = SW'(COIN_C);
  localparam logic [CREDIT_W:0]   PRICE_W = SW'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  logic [1:0]          state;
  logic [CREDIT_W-1:0] credit_q;
  logic                reject_q;

  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   cred_ext;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W:0]   greedy_val;
  logic [1:0]          greedy_code;
  logic                cancel_take;
  logic                coin_ok;

  // Decode the presented coin, form the extended sum and pick the largest change coin that fits
  always_comb begin
    coin_val    = '0;
    greedy_val  = '0;
    greedy_code = 2'b00;
    case (bus.coin_sel)
      2'b01:   coin_val = VAL_A;
      2'b10:   coin_val = VAL_B;
      2'b11:   coin_val = VAL_C;
      default: coin_val = '0;
    endcase
    cred_ext = {1'b0, credit_q};
    sum      = cred_ext + coin_val;
    if (cred_ext >= VAL_C) begin
      greedy_val  = VAL_C;
      greedy_code = 2'b11;
    end else if (cred_ext >= VAL_B) begin
      greedy_val  = VAL_B;
      greedy_code = 2'b10;
    end else if (cred_ext >= VAL_A) begin
      greedy_val  = VAL_A;
      greedy_code = 2'b01;
    end
    cancel_take = (state == S_ACCUM) && bus.cancel;
    coin_ok     = bus.coin_valid && (bus.coin_sel != 2'b00) && !sum[CREDIT_W] &&
                  ((state == S_IDLE) || (state == S_ACCUM)) && !cancel_take;
  end

  // Main state/credit register; a refund wins over a coin arriving in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      reject_q <= bus.coin_valid && !coin_ok;
      case (state)
        S_IDLE, S_ACCUM: begin
          if (cancel_take) begin
            state <= S_CHANGE;
          end else if (coin_ok) begin
            credit_q <= sum[CREDIT_W-1:0];
            state    <= (sum >= PRICE_W) ? S_VEND : S_ACCUM;
          end
        end
        S_VEND: begin
          if (bus.vend_ack) begin
            credit_q <= credit_q - PRICE_C;
            state    <= (credit_q == PRICE_C) ? S_IDLE : S_CHANGE;
          end
        end
        S_CHANGE: begin
          if (bus.change_ack) begin
            if ((greedy_val == '0) || (cred_ext == greedy_val)) begin
              credit_q <= '0;
              state    <= S_IDLE;
            end else begin
              credit_q <= credit_q - greedy_val[CREDIT_W-1:0];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef VEND_SALES_CNT_EN
  // Count accepted vends, sticking at the top value instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      sales_count <= 16'h0000;
    end else if ((state == S_VEND) && bus.vend_ack && (sales_count != 16'hFFFF)) begin
      sales_count <= sales_count + 16'h0001;
    end
  end
`endif

  assign bus.credit       = credit_q;
  assign bus.vend_req     = (state == S_VEND);
  assign bus.change_valid = (state == S_CHANGE);
  assign bus.change_coin  = (state == S_CHANGE) ? greedy_code : 2'b00;
  assign bus.coin_reject  = reject_q;
  assign bus.busy         = (state == S_VEND) || (state == S_CHANGE);

endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb_vend_ctrl_param: scoreboard bench for vend_ctrl_param.
// dutA uses the default 8-bit credit; dutB uses a 5-bit credit to exercise overflow rejection.
// When VEND_SALES_CNT_EN is defined, sales_count is checked as well.
module tb_vend_ctrl_param;

  localparam int M_IDLE   = 0;
  localparam int M_ACCUM  = 1;
  localparam int M_VEND   = 2;
  localparam int M_CHANGE = 3;

  typedef struct {
    int st;
    int credit;
    int rej;
    int sales;
  } mstate_t;

  typedef struct {
    bit       rst;
    bit       cv;
    bit [1:0] sel;
    bit       cancel;
    bit       vack;
    bit       cack;
  } stim_t;

  typedef struct {
    mstate_t a;
    mstate_t b;
  } exp_t;

  logic clk = 1'b0;
  logic rstA = 1'b1;
  logic rstB = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t expQ[$];
  exp_t monE;
  mstate_t mA = '{M_IDLE, 0, 0, 0};
  mstate_t mB = '{M_IDLE, 0, 0, 0};
  stim_t nop;

  vend_ctrl_param_if #(.CREDIT_W(8)) ifA ();
  vend_ctrl_param_if #(.CREDIT_W(5)) ifB ();

`ifdef VEND_SALES_CNT_EN
  logic [15:0] salesA;
  logic [15:0] salesB;
`endif

  vend_ctrl_param #(.PRICE(30), .CREDIT_W(8)) dutA (
    .clk(clk),
    .rst(rstA),
    .bus(ifA.slave)
`ifdef VEND_SALES_CNT_EN
    ,
    .sales_count(salesA)
`endif
  );

  vend_ctrl_param #(.PRICE(30), .CREDIT_W(5)) dutB (
    .clk(clk),
    .rst(rstB),
    .bus(ifB.slave)
`ifdef VEND_SALES_CNT_EN
    ,
    .sales_count(salesB)
`endif
  );

  always #5 clk = ~clk;

  function automatic int coinValue(input bit [1:0] sel);
    int tbl[4] = '{0, 5, 10, 25};
    return tbl[sel];
  endfunction

  function automatic int largestCoin(input int credit);
    int tbl[3] = '{25, 10, 5};
    for (int i = 0; i < 3; i++)
      if (tbl[i] <= credit) return tbl[i];
    return 0;
  endfunction

  function automatic int coinCode(input int value);
    if (value == 25) return 3;
    if (value == 10) return 2;
    if (value == 5)  return 1;
    return 0;
  endfunction

  // Behavioural reference: next model state after one clock with stimulus s
  function automatic mstate_t modelStep(input mstate_t m, input stim_t s, input int price, input int cmax);
    mstate_t n = m;
    int val = coinValue(s.sel);
    n.rej = 0;
    if (s.rst) begin
      n.st = M_IDLE;
      n.credit = 0;
      n.sales = 0;
      return n;
    end
    if (m.st == M_IDLE || m.st == M_ACCUM) begin
      if (m.st == M_ACCUM && s.cancel) begin
        n.st = M_CHANGE;
        n.rej = s.cv ? 1 : 0;
      end else if (s.cv) begin
        if (val == 0 || m.credit + val > cmax) n.rej = 1;
        else begin
          n.credit = m.credit + val;
          n.st = (n.credit >= price) ? M_VEND : M_ACCUM;
        end
      end
    end else if (m.st == M_VEND) begin
      n.rej = s.cv ? 1 : 0;
      if (s.vack) begin
        n.credit = m.credit - price;
        n.st = (n.credit > 0) ? M_CHANGE : M_IDLE;
        if (n.sales < 65535) n.sales = n.sales + 1;
      end
    end else begin
      n.rej = s.cv ? 1 : 0;
      if (s.cack) begin
        n.credit = m.credit - largestCoin(m.credit);
        if (n.credit == 0) n.st = M_IDLE;
      end
    end
    return n;
  endfunction

  function automatic stim_t mk(input bit r, input bit cv, input bit [1:0] sel,
                               input bit can, input bit va, input bit ca);
    stim_t s;
    s.rst = r; s.cv = cv; s.sel = sel; s.cancel = can; s.vack = va; s.cack = ca;
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkDut(input string p, input mstate_t m, input logic [31:0] cr,
                          input logic vr, input logic cvld, input logic [1:0] cc,
                          input logic rj, input logic bsy);
    int expCoin;
    expCoin = (m.st == M_CHANGE) ? coinCode(largestCoin(m.credit)) : 0;
    checkOutput({p, "_credit"}, cr, m.credit);
    checkOutput({p, "_vend_req"}, {31'd0, vr}, (m.st == M_VEND) ? 1 : 0);
    checkOutput({p, "_change_valid"}, {31'd0, cvld}, (m.st == M_CHANGE) ? 1 : 0);
    checkOutput({p, "_change_coin"}, {30'd0, cc}, expCoin);
    checkOutput({p, "_coin_reject"}, {31'd0, rj}, m.rej);
    checkOutput({p, "_busy"}, {31'd0, bsy}, (m.st == M_VEND || m.st == M_CHANGE) ? 1 : 0);
  endtask

  // Drive one cycle on both DUTs, advance the model and queue the expected outcome
  task automatic applyStimulus(input stim_t sa, input stim_t sb);
    exp_t e;
    @(negedge clk);
    rstA = sa.rst; ifA.coin_valid = sa.cv; ifA.coin_sel = sa.sel; ifA.cancel = sa.cancel;
    ifA.vend_ack = sa.vack; ifA.change_ack = sa.cack;
    rstB = sb.rst; ifB.coin_valid = sb.cv; ifB.coin_sel = sb.sel; ifB.cancel = sb.cancel;
    ifB.vend_ack = sb.vack; ifB.change_ack = sb.cack;
    mA = modelStep(mA, sa, 30, 255);
    mB = modelStep(mB, sb, 30, 31);
    e.a = mA;
    e.b = mB;
    expQ.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic stepA(input stim_t s);
    applyStimulus(s, nop);
  endtask

  // Pop one expected entry per clock and compare it against both DUTs
  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      checkDut("a", monE.a, {24'd0, ifA.credit}, ifA.vend_req, ifA.change_valid,
               ifA.change_coin, ifA.coin_reject, ifA.busy);
      checkDut("b", monE.b, {27'd0, ifB.credit}, ifB.vend_req, ifB.change_valid,
               ifB.change_coin, ifB.coin_reject, ifB.busy);
`ifdef VEND_SALES_CNT_EN
      checkOutput("a_sales", {16'd0, salesA}, monE.a.sales);
      checkOutput("b_sales", {16'd0, salesB}, monE.b.sales);
`endif
    end
  end

  initial begin
    nop = mk(0, 0, 2'b00, 0, 0, 0);
    ifA.coin_valid = 0; ifA.coin_sel = 0; ifA.cancel = 0; ifA.vend_ack = 0; ifA.change_ack = 0;
    ifB.coin_valid = 0; ifB.coin_sel = 0; ifB.cancel = 0; ifB.vend_ack = 0; ifB.change_ack = 0;

    applyStimulus(mk(1, 0, 2'b00, 0, 0, 0), mk(1, 0, 2'b00, 0, 0, 0));
    checkOutput("tp_reset_credit", {24'd0, ifA.credit}, 0);

    // Coin B then C, vend with 5 change
    stepA(mk(0, 1, 2'b10, 0, 0, 0));
    checkOutput("tp_credit10", {24'd0, ifA.credit}, 10);
    stepA(mk(0, 1, 2'b11, 0, 0, 0));
    checkOutput("tp_credit35", {24'd0, ifA.credit}, 35);
    checkOutput("tp_vend_req", {31'd0, ifA.vend_req}, 1);
    stepA(nop);
    stepA(mk(0, 0, 2'b00, 0, 1, 0));
    checkOutput("tp_change5", {24'd0, ifA.credit}, 5);
    checkOutput("tp_coin01", {30'd0, ifA.change_coin}, 1);
    stepA(mk(0, 0, 2'b00, 0, 0, 1));
    checkOutput("tp_idle_cv", {31'd0, ifA.change_valid}, 0);

    // Ignored acks and cancel while idle
    stepA(mk(0, 0, 2'b00, 1, 1, 1));

    // A, B, cancel: refund 10 then 5, with a stall cycle in between
    stepA(mk(0, 1, 2'b01, 0, 0, 0));
    stepA(mk(0, 1, 2'b10, 0, 0, 0));
    stepA(mk(0, 0, 2'b00, 1, 0, 0));
    checkOutput("tp_refund_coin10", {30'd0, ifA.change_coin}, 2);
    stepA(nop);
    stepA(mk(0, 0, 2'b00, 0, 0, 1));
    stepA(mk(0, 0, 2'b00, 0, 0, 1));

    // C, C, coin during VEND rejected, vend, back-to-back change acks
    stepA(mk(0, 1, 2'b11, 0, 0, 0));
    stepA(mk(0, 1, 2'b11, 0, 0, 0));
    stepA(mk(0, 1, 2'b10, 1, 0, 0));
    checkOutput("tp_vend_reject", {31'd0, ifA.coin_reject}, 1);
    checkOutput("tp_credit50", {24'd0, ifA.credit}, 50);
    stepA(mk(0, 0, 2'b00, 0, 1, 0));
    checkOutput("tp_credit20", {24'd0, ifA.credit}, 20);
    stepA(mk(0, 0, 2'b00, 0, 0, 1));
    stepA(mk(0, 0, 2'b00, 0, 0, 1));

    // Coin arriving with cancel in ACCUM is rejected, illegal code rejected
    stepA(mk(0, 1, 2'b01, 0, 0, 0));
    stepA(mk(0, 1, 2'b10, 1, 0, 0));
    stepA(mk(0, 1, 2'b00, 0, 0, 1));
    stepA(nop);

    // Exact-price vend with no change
    stepA(mk(0, 1, 2'b11, 0, 0, 0));
    stepA(mk(0, 1, 2'b01, 0, 0, 0));
    stepA(mk(0, 0, 2'b00, 0, 1, 0));
`ifdef VEND_SALES_CNT_EN
    checkOutput("tp_sales3", {16'd0, salesA}, 3);
`endif

    // Reset in the middle of a refund
    stepA(mk(0, 1, 2'b01, 0, 0, 0));
    stepA(mk(0, 1, 2'b10, 0, 0, 0));
    stepA(mk(0, 0, 2'b00, 1, 0, 0));
    stepA(mk(1, 0, 2'b00, 0, 0, 0));
    checkOutput("tp_rst_busy", {31'd0, ifA.busy}, 0);
`ifdef VEND_SALES_CNT_EN
    checkOutput("tp_sales_rst", {16'd0, salesA}, 0);
`endif
    stepA(mk(0, 1, 2'b01, 0, 0, 0));
    checkOutput("tp_after_rst5", {24'd0, ifA.credit}, 5);
    stepA(mk(0, 0, 2'b00, 1, 0, 0));
    stepA(mk(0, 0, 2'b00, 0, 0, 1));

    // Narrow credit: overflow rejection on dutB
    applyStimulus(nop, mk(0, 1, 2'b11, 0, 0, 0));
    applyStimulus(nop, mk(0, 1, 2'b10, 0, 0, 0));
    checkOutput("tp_b_overflow", {27'd0, ifB.credit}, 25);
    applyStimulus(nop, mk(0, 1, 2'b00, 0, 0, 0));
    applyStimulus(nop, mk(0, 1, 2'b01, 0, 0, 0));
    checkOutput("tp_b_credit30", {27'd0, ifB.credit}, 30);
    checkOutput("tp_b_vend_req", {31'd0, ifB.vend_req}, 1);
    applyStimulus(nop, mk(0, 0, 2'b00, 0, 1, 0));
    applyStimulus(nop, nop);

    for (int i = 0; i < 4 && expQ.size() != 0; i++) @(posedge clk);
    #2;
    checkOutput("queue_drain", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_ctrl_param.md
Name: vend_ctrl_param

Overview:
- Parametrised successor to the team's fixed-price coin vending FSM.
- Accumulates credit from three coin denominations and requests a vend once credit reaches PRICE.
- After the vend is acknowledged, dispenses change one coin at a time through a valid/ack handshake; a cancel refunds all credit the same way.
- Sits between the coin acceptor front end and the dispenser/change hopper.

Parameters:
- PRICE, 30, item price in credit units; must be a multiple of COIN_A and at most 2^CREDIT_W-1.
- CREDIT_W, 8, width of the credit register.
- COIN_A, 5, value of coin code 2'b01; smallest coin.
- COIN_B, 10, value of coin code 2'b10; multiple of COIN_A.
- COIN_C, 25, value of coin code 2'b11; multiple of COIN_A; COIN_A < COIN_B < COIN_C.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- coin_valid  in  1  coin present this cycle.
- coin_sel  in  2  coin code: 01=A, 10=B, 11=C; 00 is illegal.
- cancel  in  1  refund request.
- vend_ack  in  1  dispenser accepted the vend.
- change_ack  in  1  hopper accepted the current change coin.
- credit  out  CREDIT_W  current credit.
- vend_req  out  1  vend request; held until vend_ack.
- change_valid  out  1  change coin request.
- change_coin  out  2  code of the coin to return (01/10/11).
- coin_reject  out  1  one-cycle pulse: presented coin was not accepted.
- busy  out  1  high in VEND or CHANGE.

Behaviour:
- Reset (rst high at posedge): state IDLE, credit=0; vend_req, change_valid, coin_reject, busy all 0; change_coin=00. Reset overrides everything, including mid-vend and mid-change; no pending handshake survives it.
- States: IDLE (credit==0), ACCUM (0<credit<PRICE), VEND, CHANGE.
- Coin acceptance in IDLE/ACCUM with coin_valid=1, coin_sel!=00, and credit+value <= 2^CREDIT_W-1:
  - credit <= credit+value at that edge.
  - Next state is VEND if new credit >= PRICE, otherwise ACCUM.
  - vend_req is therefore high the cycle after the coin is sampled.
- Coin rejection: coin_sel==00, credit overflow, coin in VEND/CHANGE, or coin together with an accepted cancel.
  - coin_reject=1 for exactly the following cycle; credit unchanged.
- Arithmetic: sum computed CREDIT_W+1 bits wide for the overflow check; no wrap-around ever reaches credit.
- VEND: vend_req=1 until vend_ack sampled high.
  - On ack: credit <= credit-PRICE, vend_req drops next cycle.
  - Next state CHANGE if remainder>0, else IDLE.
  - cancel ignored in VEND.
- cancel in ACCUM: go to CHANGE with full credit (refund). cancel in IDLE or CHANGE: no effect.
- CHANGE: change_valid=1; change_coin = code of the largest coin with value <= credit (greedy).
  - On change_ack with change_valid: credit <= credit-value.
  - change_coin is recomputed from the new credit; it is stable while valid and not acked.
  - When credit reaches 0: change_valid=0 next cycle, state IDLE, change_coin=00.
  - One coin per ack; back-to-back acks allowed (one coin per cycle).
- vend_ack outside VEND and change_ack outside CHANGE are ignored.
- busy = (state==VEND) or (state==CHANGE), registered with the state.

Optional Feature:
- Macro: VEND_SALES_CNT_EN.
- Defined: adds output sales_count [15:0], reset to 0, incremented on each vend_ack accepted in VEND, saturating at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, coin B then coin C -> credit 10 then 35; vend_req=1 the cycle after C; vend_ack -> credit 5, change_valid=1, change_coin=01; change_ack -> credit 0, IDLE, change_valid=0.
- Coin A, coin B (credit 15), cancel -> CHANGE; change_coin=10, ack -> credit 5; change_coin=01, ack -> credit 0, IDLE; vend_req never asserted.
- Coin C, coin C -> credit 50, VEND; coin B during VEND -> coin_reject pulse, credit stays 50; vend_ack -> credit 20; change coins 10, 10 -> IDLE.
- CREDIT_W=5, PRICE=30: coin C (25), coin B -> rejected (35>31), credit 25; coin_sel=00 with coin_valid -> rejected; coin A -> credit 30, vend_req.
- Credit 15 in CHANGE with change_valid=1, assert rst -> next cycle credit=0, change_valid=0, busy=0, state IDLE; coin A after reset -> credit 5.
- With VEND_SALES_CNT_EN: three complete vends -> sales_count=3; rst -> 0.
